// File: rtl/rfphoenix_vec_wb_queue_pkg.sv
// Shared vector-unit types for the writeback path.
//   NLANES   : lanes per vector value
//   Value    : one lane
//   VecValue : NLANES lanes, lane 0 in the low bits
//   WbEntry  : one queued writeback {rt, tt, mask, res}
package rfPhoenixPkg;

  localparam int unsigned NLANES = 16;
  localparam int unsigned VALW   = 32;

  typedef logic [VALW-1:0]    Value;
  typedef Value [NLANES-1:0]  VecValue;

  typedef struct packed {
    logic [5:0]        rt;    // destination register
    logic              tt;    // 1 = vector target, 0 = scalar
    logic [NLANES-1:0] mask;  // lane write enables
    VecValue           res;   // result data
  } WbEntry;

endpackage

// File: rtl/rfphoenix_wb_fwd_match.sv
// Forwarding lookup over the writeback queue entries.
// Searches the valid entries and reports the newest one whose register
// number and target type match the lookup.
//   entries_i : queue storage
//   valid_i   : per-slot occupancy
//   tail_i    : next write slot (newest entry sits just below it)
//   ra_i/ta_i : register number / vector flag being looked up
//   hit_o     : match with full mask (or scalar target), data usable
//   partial_o : match with partial mask, consumer must stall
//   data_o    : matching entry's data, zero when nothing matches
module rfphoenix_wb_fwd_match
  import rfPhoenixPkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  WbEntry            entries_i [DEPTH],
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [PW-1:0]     tail_i,
  input  logic [5:0]        ra_i,
  input  logic              ta_i,
  output logic              hit_o,
  output logic              partial_o,
  output VecValue           data_o
);

  logic          match;
  logic          full_ok;
  WbEntry        sel;
  logic [PW-1:0] idx;

  // Walk slots from tail (oldest when full) up to tail-1 (newest);
  // a later match overrides an earlier one, so the newest entry wins.
  always_comb begin
    match = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = tail_i + k[PW-1:0];
      if (valid_i[idx] && (entries_i[idx].rt == ra_i) && (entries_i[idx].tt == ta_i)) begin
        match = 1'b1;
        sel   = entries_i[idx];
      end
    end
  end

  assign full_ok   = (&sel.mask) | ~sel.tt;
  assign hit_o     = match & full_ok;
  assign partial_o = match & ~full_ok;
  assign data_o    = sel.res;  // sel stays zero when nothing matches

endmodule

// File: rtl/rfphoenix_vec_wb_queue.sv
// Writeback queue between the vector ALU and the register-file write port.
// In-order circular buffer of DEPTH WbEntry flops with a combinational
// forwarding lookup for the operand fetch stage.
//   clk, rst        : clock, synchronous active-high reset
//   i_v/i_rdy       : ALU result handshake
//   i_rt/i_tt/i_mask/i_res : incoming result fields
//   wr_v/wr_ack     : head-entry handshake toward the register file
//   wr_rt/wr_tt/wr_mask/wr_res : head entry fields
//   fwd_ra/fwd_ta   : forwarding lookup key
//   fwd_hit/fwd_partial/fwd_res : forwarding result
//   count           : occupied entries
module rfphoenix_vec_wb_queue
  import rfPhoenixPkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_v,
  output logic                    i_rdy,
  input  logic [5:0]              i_rt,
  input  logic                    i_tt,
  input  logic [NLANES-1:0]       i_mask,
  input  VecValue                 i_res,
  output logic                    wr_v,
  input  logic                    wr_ack,
  output logic [5:0]              wr_rt,
  output logic                    wr_tt,
  output logic [NLANES-1:0]       wr_mask,
  output VecValue                 wr_res,
  input  logic [5:0]              fwd_ra,
  input  logic                    fwd_ta,
  output logic                    fwd_hit,
  output logic                    fwd_partial,
  output VecValue                 fwd_res,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  WbEntry           mem_q [DEPTH];
  WbEntry           in_entry;
  logic             enq;
  logic             pop;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    off;

  assign i_rdy = ~rst & (count_q != CW'(DEPTH));
  assign wr_v  = ~rst & (count_q != '0);

  // An empty-mask vector result is accepted but dropped.
  assign enq = i_v & i_rdy & (~i_tt | (|i_mask));
  assign pop = wr_v & wr_ack;

  always_comb begin
    in_entry      = '0;
    in_entry.rt   = i_rt;
    in_entry.tt   = i_tt;
    in_entry.mask = i_tt ? i_mask : NLANES'(1);
    in_entry.res  = i_res;
  end

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(enq);
    count_d = count_q + CW'(enq) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= in_entry;
  end

  assign wr_rt   = mem_q[head_q].rt;
  assign wr_tt   = mem_q[head_q].tt;
  assign wr_mask = mem_q[head_q].mask;
  assign wr_res  = mem_q[head_q].res;
  assign count   = count_q;

  // A slot is occupied when its distance from head is below count.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - head_q;
      valid[i] = ~rst & ({1'b0, off} < count_q);
    end
  end

  rfphoenix_wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .entries_i (mem_q),
    .valid_i   (valid),
    .tail_i    (tail_q),
    .ra_i      (fwd_ra),
    .ta_i      (fwd_ta),
    .hit_o     (fwd_hit),
    .partial_o (fwd_partial),
    .data_o    (fwd_res)
  );

endmodule

// File: tb/tb_rfphoenix_vec_wb_queue.sv
module tb_rfphoenix_vec_wb_queue;
  import rfPhoenixPkg::*;

  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_v;
  logic              i_rdy;
  logic [5:0]        i_rt;
  logic              i_tt;
  logic [NLANES-1:0] i_mask;
  VecValue           i_res;
  logic              wr_v;
  logic              wr_ack;
  logic [5:0]        wr_rt;
  logic              wr_tt;
  logic [NLANES-1:0] wr_mask;
  VecValue           wr_res;
  logic [5:0]        fwd_ra;
  logic              fwd_ta;
  logic              fwd_hit;
  logic              fwd_partial;
  VecValue           fwd_res;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  WbEntry sb[$];
  WbEntry mexp;

  rfphoenix_vec_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_v(i_v), .i_rdy(i_rdy), .i_rt(i_rt), .i_tt(i_tt),
    .i_mask(i_mask), .i_res(i_res), .wr_v(wr_v), .wr_ack(wr_ack), .wr_rt(wr_rt),
    .wr_tt(wr_tt), .wr_mask(wr_mask), .wr_res(wr_res), .fwd_ra(fwd_ra),
    .fwd_ta(fwd_ta), .fwd_hit(fwd_hit), .fwd_partial(fwd_partial),
    .fwd_res(fwd_res), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input VecValue act, input VecValue exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic VecValue mkres(input logic [31:0] base);
    VecValue r;
    for (int n = 0; n < int'(NLANES); n++) r[n] = base + 32'(n);
    return r;
  endfunction

  // Scoreboard monitor: every transfer on the write port must match the
  // oldest outstanding expected entry.
  always @(negedge clk) begin
    if (!rst && wr_v && wr_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got wr_rt %0d expected no entry", wr_rt);
      end else begin
        mexp = sb.pop_front();
        chk("wr_rt", 32'(wr_rt), 32'(mexp.rt));
        chk("wr_tt", 32'(wr_tt), 32'(mexp.tt));
        chk("wr_mask", 32'(wr_mask), 32'(mexp.mask));
        chkv("wr_res", wr_res, mexp.res);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a push for the coming edge; the model enqueues only what the
  // queue is expected to accept and keep.
  task automatic start_push(input logic [5:0] rt, input logic tt,
                            input logic [NLANES-1:0] mask, input VecValue res);
    WbEntry e;
    i_v = 1'b1; i_rt = rt; i_tt = tt; i_mask = mask; i_res = res;
    e.rt = rt; e.tt = tt; e.mask = tt ? mask : 16'h0001; e.res = res;
    if (sb.size() != DEPTH && (!tt || mask != '0)) sb.push_back(e);
  endtask

  task automatic push1(input logic [5:0] rt, input logic tt,
                       input logic [NLANES-1:0] mask, input VecValue res);
    start_push(rt, tt, mask, res);
    tick();
    i_v = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    wr_ack = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    wr_ack = 1'b0;
    chk("drain_left", 32'(sb.size()), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_v = 1'b0; i_rt = '0; i_tt = 1'b0; i_mask = '0; i_res = '0;
    wr_ack = 1'b0; fwd_ra = '0; fwd_ta = 1'b0;
    tick(); tick();
    chk("rst_i_rdy", 32'(i_rdy), 32'd0);
    chk("rst_wr_v", 32'(wr_v), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_wr_v", 32'(wr_v), 32'd0);
    chk("post_rst_hit", 32'(fwd_hit), 32'd0);
    chk("post_rst_i_rdy", 32'(i_rdy), 32'd1);

    // Latency and hold-stable head.
    push1(6'd5, 1'b1, 16'hFFFF, mkres(32'h100));
    chk("lat_wr_v", 32'(wr_v), 32'd1);
    chk("lat_wr_rt", 32'(wr_rt), 32'd5);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_wr_v", 32'(wr_v), 32'd1);
      chk("hold_wr_rt", 32'(wr_rt), 32'd5);
      chkv("hold_wr_res", wr_res, mkres(32'h100));
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("ack_count", 32'(count), 32'd0);
    chk("ack_wr_v", 32'(wr_v), 32'd0);

    // Fill to full; a fifth push is refused.
    for (int r = 1; r <= 4; r++) push1(6'(r), 1'b1, 16'hFFFF, mkres(32'(r) << 8));
    chk("full_count", 32'(count), 32'd4);
    chk("full_i_rdy", 32'(i_rdy), 32'd0);
    push1(6'd6, 1'b1, 16'hFFFF, mkres(32'h600));
    chk("full_no_push", 32'(count), 32'd4);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("after_pop_i_rdy", 32'(i_rdy), 32'd1);
    chk("after_pop_count", 32'(count), 32'd3);
    drain();

    // Steady push+pop across pointer wrap.
    for (int r = 10; r <= 12; r++) push1(6'(r), 1'b1, 16'hFFFF, mkres(32'(r) << 8));
    chk("fill3_count", 32'(count), 32'd3);
    wr_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push1(6'(20 + k), 1'b1, 16'hFFFF, mkres(32'(20 + k) << 8));
      chk("stream_count", 32'(count), 32'd3);
    end
    drain();

    // Scalar mask forcing and dropped empty-mask vector.
    push1(6'd7, 1'b0, 16'h0000, mkres(32'h700));
    chk("scalar_count", 32'(count), 32'd1);
    chk("scalar_wr_mask", 32'(wr_mask), 32'h0001);
    push1(6'd8, 1'b1, 16'h0000, mkres(32'h800));
    chk("empty_mask_count", 32'(count), 32'd1);
    drain();

    // Forwarding.
    fwd_ra = 6'd9; fwd_ta = 1'b1;
    push1(6'd9, 1'b1, 16'hFFFF, mkres(32'hA000));
    chk("fwd_full_hit", 32'(fwd_hit), 32'd1);
    chkv("fwd_full_res", fwd_res, mkres(32'hA000));
    push1(6'd9, 1'b1, 16'h00FF, mkres(32'hB000));
    chk("fwd_part_partial", 32'(fwd_partial), 32'd1);
    chk("fwd_part_hit", 32'(fwd_hit), 32'd0);
    chkv("fwd_part_res", fwd_res, mkres(32'hB000));
    fwd_ta = 1'b0;
    #1;
    chk("fwd_miss_hit", 32'(fwd_hit), 32'd0);
    chk("fwd_miss_partial", 32'(fwd_partial), 32'd0);
    chkv("fwd_miss_res", fwd_res, '0);
    start_push(6'd9, 1'b0, 16'h0000, mkres(32'hD000));
    #1;
    chk("fwd_inflight_hit", 32'(fwd_hit), 32'd0);
    tick();
    i_v = 1'b0;
    chk("fwd_scalar_hit", 32'(fwd_hit), 32'd1);
    chk("fwd_scalar_partial", 32'(fwd_partial), 32'd0);
    chkv("fwd_scalar_res", fwd_res, mkres(32'hD000));
    drain();

    // Reset mid-occupancy discards everything.
    for (int r = 30; r <= 32; r++) push1(6'(r), 1'b1, 16'hFFFF, mkres(32'(r) << 8));
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_wr_v", 32'(wr_v), 32'd0);
    fwd_ra = 6'd30; fwd_ta = 1'b1;
    #1;
    chk("mid_rst_hit", 32'(fwd_hit), 32'd0);
    chk("mid_rst_partial", 32'(fwd_partial), 32'd0);
    push1(6'd40, 1'b1, 16'hFFFF, mkres(32'h4000));
    chk("rst_head_wr_v", 32'(wr_v), 32'd1);
    chk("rst_head_wr_rt", 32'(wr_rt), 32'd40);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
